// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word stores and sign/zero-extended loads, one request in flight.
// Latency: response valid is sampled high WAIT_STATES+1 edges after the accept edge.
// Backpressure: response held stable until i_rsp_ready; o_req_ready is low outside IDLE. Option: DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_mode,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LOW_W = IDX_W + 2;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 accept;
    logic                 enter_resp;

    logic                 we_q;
    logic [2:0]           mode_q;
    logic [LOW_W-1:0]     addr_q;
    logic [31:0]          wdata_q;

    logic                 acc_we;
    logic [2:0]           acc_mode;
    logic [LOW_W-1:0]     acc_addr;
    logic [31:0]          acc_wdata;
    logic [IDX_W-1:0]     acc_idx;
    logic                 acc_err;
    logic [3:0]           acc_be;
    logic [31:0]          acc_wd;
    logic                 mem_wr;

    logic [31:0]          mem [DEPTH_WORDS];
    logic [31:0]          rd_word;
    logic [31:0]          rd_shift;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic [31:0]          load_data;
    logic                 rsp_err;

    // Only the RAM-indexing address bits are meaningful; the rest alias.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^i_req_addr[ADDR_WIDTH-1:LOW_W];

    function automatic logic access_err(input logic we, input logic [2:0] mode, input logic [1:0] lo);
        logic illegal;
        logic misalign;
        illegal  = (mode == 3'b011) || (mode[2:1] == 2'b11) || (we && mode[2]);
`ifdef DMEM_MISALIGN_ERR_EN
        misalign = ((mode[1:0] == 2'b01) && lo[0]) || ((mode[1:0] == 2'b10) && (lo != 2'b00));
`else
        misalign = 1'b0 & (^lo);
`endif
        return illegal || misalign;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mode_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= i_req_we;
                mode_q  <= i_req_mode;
                addr_q  <= i_req_addr[LOW_W-1:0];
                wdata_q <= i_req_wdata;
            end
        end
    end

    // With zero wait states the RAM is touched on the accept edge itself, before the latch holds the request.
    always_comb begin
        acc_we    = (state_q == ST_IDLE) ? i_req_we                 : we_q;
        acc_mode  = (state_q == ST_IDLE) ? i_req_mode               : mode_q;
        acc_addr  = (state_q == ST_IDLE) ? i_req_addr[LOW_W-1:0]    : addr_q;
        acc_wdata = (state_q == ST_IDLE) ? i_req_wdata              : wdata_q;
        acc_idx   = acc_addr[LOW_W-1:2];
        acc_err   = access_err(acc_we, acc_mode, acc_addr[1:0]);
        acc_be    = lane_enables(acc_mode[1:0], acc_addr[1:0]);
        acc_wd    = lane_data(acc_mode[1:0], acc_wdata);
    end

    // Gating with n_rst keeps a request presented during reset from reaching the RAM.
    assign mem_wr = enter_resp && acc_we && !acc_err && n_rst;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int l = 0; l < 4; l++) begin
                if (acc_be[l]) begin
                    mem[acc_idx][8*l +: 8] <= acc_wd[8*l +: 8];
                end
            end
        end
        if (enter_resp) begin
            rd_word <= mem[acc_idx];
        end
    end

    always_comb begin
        rd_shift = rd_word >> {addr_q[1:0], 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (mode_q)
            MODE_B:  load_data = {{24{rd_byte[7]}}, rd_byte};
            MODE_BU: load_data = {24'd0, rd_byte};
            MODE_H:  load_data = {{16{rd_half[15]}}, rd_half};
            MODE_HU: load_data = {16'd0, rd_half};
            MODE_W:  load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    assign rsp_err     = access_err(we_q, mode_q, addr_q[1:0]);
    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_err   = (state_q == ST_RESP) && rsp_err;
    assign o_rsp_rdata = ((state_q == ST_RESP) && !we_q && !rsp_err) ? load_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed memory model.
module tb_dmem_responder;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_mode = 3'b000;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] mb [4096];

    dmem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_WORDS(1024),
        .WAIT_STATES(WS)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_we   (i_req_we),
        .i_req_mode (i_req_mode),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err  (o_rsp_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory as 4 KiB of bytes, little-endian; the address wraps modulo the RAM size.
    task automatic model_access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        int a;
        int size;
        logic [31:0] v;
        a    = int'(addr & 32'h0000_0FFF);
        size = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
        err  = (mode == 3'd3) || (mode == 3'd6) || (mode == 3'd7) || (we && mode >= 3'd4);
`ifdef DMEM_MISALIGN_ERR_EN
        if ((a % size) != 0) err = 1'b1;
`else
        a = a - (a % size);
`endif
        rd = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mb[a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[a + i]) << (8 * i));
            if (mode < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the response handshake.
    task automatic xfer(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit poke,
                        output logic [31:0] rd, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int n;
        int lat;
        n = 0;
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(n >= 50), 32'd0);
        model_access(we, mode, addr, wdata, exp_rd, exp_err);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_mode  = mode;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!o_rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(WS + 1));
        rd  = o_rsp_rdata;
        err = o_rsp_err;
        check("rdata", o_rsp_rdata, exp_rd);
        check("err", 32'(o_rsp_err), 32'(exp_err));
        if (poke) begin
            i_req_valid = 1'b1;
            i_req_we    = 1'b1;
            i_req_mode  = 3'b010;
            i_req_addr  = 32'h80;
            i_req_wdata = 32'hBAD0_BAD0;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(o_rsp_valid), 32'd1);
            check("hold_rdata", o_rsp_rdata, exp_rd);
            check("hold_err", 32'(o_rsp_err), 32'(exp_err));
            check("hold_req_ready", 32'(o_req_ready), 32'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("valid_drop", 32'(o_rsp_valid), 32'd0);
        check("ready_back", 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w40;
        logic        err;
        logic [31:0] ra;
        logic [31:0] rw;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rdata", o_rsp_rdata, 32'd0);
        check("rst_err", 32'(o_rsp_err), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            xfer(1'b1, 3'b010, 32'(4 * i), $urandom(), 0, 1'b0, rd, err);
        end

        xfer(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, err);
        xfer(1'b0, 3'b010, 32'h10, 32'd0, 0, 1'b0, rd, err);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);
        check("lw_deadbeef_err", 32'(err), 32'd0);

        xfer(1'b1, 3'b010, 32'h10, 32'h1122_3344, 0, 1'b0, rd, err);
        xfer(1'b1, 3'b000, 32'h13, 32'h0000_0080, 1, 1'b0, rd, err);
        xfer(1'b0, 3'b000, 32'h13, 32'd0, 0, 1'b0, rd, err);
        check("lb_13", rd, 32'hFFFF_FF80);
        xfer(1'b0, 3'b100, 32'h13, 32'd0, 0, 1'b0, rd, err);
        check("lbu_13", rd, 32'h0000_0080);
        xfer(1'b0, 3'b010, 32'h10, 32'd0, 0, 1'b0, rd, err);
        check("lw_10_merged", rd, 32'h8022_3344);

        xfer(1'b1, 3'b010, 32'h20, 32'd0, 0, 1'b0, rd, err);
        xfer(1'b1, 3'b001, 32'h22, 32'h0000_8001, 0, 1'b0, rd, err);
        xfer(1'b0, 3'b001, 32'h22, 32'd0, 0, 1'b0, rd, err);
        check("lh_22", rd, 32'hFFFF_8001);
        xfer(1'b0, 3'b101, 32'h22, 32'd0, 0, 1'b0, rd, err);
        check("lhu_22", rd, 32'h0000_8001);
        xfer(1'b0, 3'b010, 32'h20, 32'd0, 0, 1'b0, rd, err);
        check("lw_20_merged", rd, 32'h8001_0000);

        // Stalled response with a competing store held on the request side.
        xfer(1'b0, 3'b010, 32'h10, 32'd0, 5, 1'b1, rd, err);
        xfer(1'b0, 3'b010, 32'h80, 32'd0, 0, 1'b0, rd, err);

        xfer(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 0, 1'b0, rd, err);
        xfer(1'b0, 3'b010, 32'h41, 32'd0, 0, 1'b0, rd, err);
`ifdef DMEM_MISALIGN_ERR_EN
        check("lw_41_err", 32'(err), 32'd1);
        check("lw_41_rdata", rd, 32'd0);
`else
        check("lw_41_err", 32'(err), 32'd0);
        check("lw_41_rdata", rd, 32'hCAFE_F00D);
`endif
        xfer(1'b0, 3'b011, 32'h40, 32'd0, 0, 1'b0, rd, err);
        check("mode011_err", 32'(err), 32'd1);
        xfer(1'b1, 3'b100, 32'h40, 32'h0000_00AA, 0, 1'b0, rd, err);
        check("sbu_err", 32'(err), 32'd1);
        xfer(1'b0, 3'b010, 32'h40, 32'd0, 0, 1'b0, rd, err);
        check("sbu_no_write", rd, 32'hCAFE_F00D);

        // Reset while a store sits in WAIT: the store must never land.
        xfer(1'b0, 3'b010, 32'h10, 32'd0, 0, 1'b0, w40, err);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_mode  = 3'b010;
        i_req_addr  = 32'h10;
        i_req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        n_rst = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 32'(o_req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        xfer(1'b0, 3'b010, 32'h10, 32'd0, 0, 1'b0, rd, err);
        check("midrst_store_dropped", rd, w40);

        for (int i = 0; i < 250; i++) begin
            ra = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            rw = $urandom();
            xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rw,
                 $urandom_range(0, 3), 1'b0, rd, err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
